ppe_ifmap_client: RTL and testbench

PE-side client of the IFMAP memory protocol. It receives input-row packets from the router, buffers them, and hands them to the PE datapath. It also initiates the per-PE row-request packets that make the IFMAP memory send the next row. One instance sits on each input PE (PE_ID 5..9) between the router port and the PE compute core, and it is clocked and synchronous.

---
 rtl/ppe_ifmap_client.sv | 143 ++++++++++++++
 tb/tb_ppe_ifmap_client.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_ifmap_client.sv
// PE-side IFMAP client: buffers input-row packets from the router in a 2-entry FIFO
// and issues one row-request packet at a time to the IFMAP memory.
module ppe_ifmap_client #(
    parameter int PE_ID       = 5,
    parameter int IMEM_ID     = 10,
    parameter int IFMAP_SIZE  = 25,
    parameter int ROWS_PER_TS = 5,
    parameter int ROW_STRIDE  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ts_start,
    input  logic                  pkt_in_valid,
    output logic                  pkt_in_ready,
    input  logic [IFMAP_SIZE+7:0] pkt_in_data,
    output logic                  pkt_out_valid,
    input  logic                  pkt_out_ready,
    output logic [IFMAP_SIZE+7:0] pkt_out_data,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [IFMAP_SIZE-1:0] row_data,
    output logic [4:0]            row_index,
    output logic                  ts_done,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    // Debug encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] PE_ADDR   = 4'(PE_ID);
    localparam logic [3:0] IMEM_ADDR = 4'(IMEM_ID);
    localparam logic [4:0] BASE_IDX  = 5'(PE_ID - 5);
    localparam logic [2:0] ROWS      = 3'(ROWS_PER_TS);

    // Handshakes: every transfer (router in, request out, row to core) happens
    // at a rising edge where valid and ready are both high; valid never waits on ready.

    state_t                state;
    logic [2:0]            recv_cnt;
    logic [2:0]            req_cnt;
    logic [2:0]            pop_cnt;
    logic                  outstanding;
    logic [1:0]            fifo_cnt;
    logic                  rd_ptr;
    logic [IFMAP_SIZE-1:0] mem_data [2];
    logic [4:0]            mem_idx  [2];

    logic       in_fire;
    logic       row_ok;
    logic       push;
    logic       pop;
    logic       req_go;
    logic       start_ok;
    logic       wr_ptr;
    logic [4:0] push_idx;
    logic [4:0] req_idx;

    assign pkt_in_ready = (fifo_cnt < 2'd2);
    assign row_valid    = (fifo_cnt != 2'd0);
    assign row_data     = mem_data[rd_ptr];
    assign row_index    = mem_idx[rd_ptr];
    assign dbg_state    = state;

    assign in_fire  = pkt_in_valid && pkt_in_ready;
    // The first row of a timestep arrives unsolicited; later rows need a request in flight.
    assign row_ok   = (pkt_in_data[IFMAP_SIZE+7:IFMAP_SIZE+4] == PE_ADDR) &&
                      (pkt_in_data[IFMAP_SIZE+3:IFMAP_SIZE] == 4'd1) &&
                      (state == RUN) && ((recv_cnt == 3'd0) || outstanding);
    assign push     = in_fire && row_ok;
    assign pop      = row_valid && row_ready;
    assign start_ok = ts_start && (state != RUN);
    assign wr_ptr   = rd_ptr ^ fifo_cnt[0];
    assign push_idx = BASE_IDX + 5'(ROW_STRIDE * int'(recv_cnt));
    assign req_idx  = BASE_IDX + 5'(ROW_STRIDE * int'(req_cnt));
    assign req_go   = (state == RUN) && (recv_cnt != 3'd0) && !outstanding &&
                      !pkt_out_valid && (req_cnt < ROWS) && !fifo_cnt[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            recv_cnt      <= 3'd0;
            req_cnt       <= 3'd0;
            pop_cnt       <= 3'd0;
            outstanding   <= 1'b0;
            fifo_cnt      <= 2'd0;
            rd_ptr        <= 1'b0;
            mem_data[0]   <= '0;
            mem_data[1]   <= '0;
            mem_idx[0]    <= 5'd0;
            mem_idx[1]    <= 5'd0;
            pkt_out_valid <= 1'b0;
            pkt_out_data  <= '0;
            ts_done       <= 1'b0;
            err           <= 1'b0;
        end else begin
            err     <= in_fire && !row_ok;
            ts_done <= 1'b0;
            if (start_ok) begin
                state         <= RUN;
                recv_cnt      <= 3'd0;
                req_cnt       <= 3'd1;
                pop_cnt       <= 3'd0;
                outstanding   <= 1'b0;
                fifo_cnt      <= 2'd0;
                rd_ptr        <= 1'b0;
                pkt_out_valid <= 1'b0;
            end else begin
                if (push) begin
                    mem_data[wr_ptr] <= pkt_in_data[IFMAP_SIZE-1:0];
                    mem_idx[wr_ptr]  <= push_idx;
                    outstanding      <= 1'b0;
                    if (recv_cnt < ROWS)
                        recv_cnt <= recv_cnt + 3'd1;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
                if (pop && (state == RUN) && (pop_cnt < ROWS)) begin
                    pop_cnt <= pop_cnt + 3'd1;
                    if (pop_cnt == ROWS - 3'd1) begin
                        state   <= DONE;
                        ts_done <= 1'b1;
                    end
                end
                if (pkt_out_valid && pkt_out_ready) begin
                    pkt_out_valid <= 1'b0;
                    outstanding   <= 1'b1;
                    if (req_cnt < ROWS)
                        req_cnt <= req_cnt + 3'd1;
                end else if (req_go) begin
                    pkt_out_valid <= 1'b1;
                    pkt_out_data  <= {IMEM_ADDR, PE_ADDR, {(IFMAP_SIZE-5){1'b0}}, req_idx};
                end
            end
        end
    end

endmodule

// File: tb/tb_ppe_ifmap_client.sv
// Bench for ppe_ifmap_client: instance 0 is PE_ID=5, instance 1 is PE_ID=7.
// Expected rows and requests come from the row-index formula and a row queue.
module tb_ppe_ifmap_client;

    localparam logic [1:0] ST_DONE = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ts_start      [2];
    logic        pkt_in_valid  [2];
    logic        pkt_in_ready  [2];
    logic [32:0] pkt_in_data   [2];
    logic        pkt_out_valid [2];
    logic        pkt_out_ready [2];
    logic [32:0] pkt_out_data  [2];
    logic        row_valid     [2];
    logic        row_ready     [2];
    logic [24:0] row_data      [2];
    logic [4:0]  row_index     [2];
    logic        ts_done       [2];
    logic        err           [2];
    logic [1:0]  dbg_state     [2];

    int total = 0;
    int bad   = 0;
    logic [29:0] exp_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ppe_ifmap_client #(.PE_ID(5 + 2 * g)) dut (
            .clk(clk), .reset(reset), .ts_start(ts_start[g]),
            .pkt_in_valid(pkt_in_valid[g]), .pkt_in_ready(pkt_in_ready[g]),
            .pkt_in_data(pkt_in_data[g]),
            .pkt_out_valid(pkt_out_valid[g]), .pkt_out_ready(pkt_out_ready[g]),
            .pkt_out_data(pkt_out_data[g]),
            .row_valid(row_valid[g]), .row_ready(row_ready[g]),
            .row_data(row_data[g]), .row_index(row_index[g]),
            .ts_done(ts_done[g]), .err(err[g]), .dbg_state(dbg_state[g])
        );
    end

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            ts_start[i]      = 1'b0;
            pkt_in_valid[i]  = 1'b0;
            pkt_in_data[i]   = '0;
            pkt_out_ready[i] = 1'b0;
            row_ready[i]     = 1'b0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start(input int p);
        ts_start[p] = 1'b1;
        tick();
        ts_start[p] = 1'b0;
    endtask

    task automatic send_pkt(input int p, input logic [3:0] dest, input logic [3:0] opc,
                            input logic [24:0] data);
        pkt_in_valid[p] = 1'b1;
        pkt_in_data[p]  = {dest, opc, data};
        tick();
        pkt_in_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] d;
        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (pkt_in_ready[i] !== 1'b1 || pkt_out_valid[i] !== 1'b0 || pkt_out_data[i] !== 33'd0 ||
                row_valid[i] !== 1'b0 || row_data[i] !== 25'd0 || row_index[i] !== 5'd0 ||
                ts_done[i] !== 1'b0 || err[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_values inst%0d: in_rdy=%b out_v=%b out_d=%h row_v=%b row_d=%h idx=%0d done=%b err=%b, want 1 0 0 0 0 0 0 0",
                         i, pkt_in_ready[i], pkt_out_valid[i], pkt_out_data[i], row_valid[i],
                         row_data[i], row_index[i], ts_done[i], err[i]);
            end
        end
        reset = 1'b0;
        tick();
        // Reach RUN with a request pending, then reset between clock edges.
        do_start(0);
        d = 25'($urandom);
        send_pkt(0, 4'd5, 4'd1, d);
        tick();
        total++;
        if (pkt_out_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_setup_req: pkt_out_valid=%b want 1", pkt_out_valid[0]);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (pkt_in_ready[0] !== 1'b1 || pkt_out_valid[0] !== 1'b0 || pkt_out_data[0] !== 33'd0 ||
            row_valid[0] !== 1'b0 || row_data[0] !== 25'd0 || row_index[0] !== 5'd0 ||
            ts_done[0] !== 1'b0 || err[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: in_rdy=%b out_v=%b out_d=%h row_v=%b row_d=%h idx=%0d done=%b err=%b, want reset values",
                     pkt_in_ready[0], pkt_out_valid[0], pkt_out_data[0], row_valid[0], row_data[0],
                     row_index[0], ts_done[0], err[0]);
        end
        tick();
        reset = 1'b0;
        tick();
        send_pkt(0, 4'd5, 4'd1, 25'($urandom));
        total++;
        if (err[0] !== 1'b1 || row_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_row: err=%b row_valid=%b want 1 0", err[0], row_valid[0]);
        end
    endtask

    task automatic test_first_row();
        apply_reset();
        do_start(0);
        send_pkt(0, 4'd5, 4'd1, 25'h1ABCDEF);
        total++;
        if (row_valid[0] !== 1'b1 || row_data[0] !== 25'h1ABCDEF || row_index[0] !== 5'd0 ||
            pkt_out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL first_row: row_v=%b data=%h idx=%0d out_v=%b want 1 1abcdef 0 0",
                     row_valid[0], row_data[0], row_index[0], pkt_out_valid[0]);
        end
        tick();
        total++;
        if (pkt_out_valid[0] !== 1'b1 || pkt_out_data[0] !== {4'd10, 4'd5, 25'd5}) begin
            bad++;
            $display("FAIL first_request: out_v=%b data=%h want 1 %h",
                     pkt_out_valid[0], pkt_out_data[0], {4'd10, 4'd5, 25'd5});
        end
    endtask

    // Randomized full timestep on PE_ID=7 with a memory responder and a row scoreboard.
    task automatic test_full_timestep();
        int p = 1;
        int rows_sent = 0, rows_popped = 0, reqs = 0, done_pulses = 0;
        int reply_wait, pop_cyc = -10, done_cyc = -1, cyc = 0;
        logic accepted;
        logic [29:0] e;
        apply_reset();
        exp_q.delete();
        do_start(p);
        reply_wait = $urandom_range(0, 3);
        while (cyc < 400 && (rows_popped < 5 || cyc < pop_cyc + 5)) begin
            if (ts_done[p]) begin
                done_pulses++;
                done_cyc = cyc;
            end
            row_ready[p]     = ($urandom_range(0, 3) != 0);
            pkt_out_ready[p] = ($urandom_range(0, 2) != 0);
            if (!pkt_in_valid[p] && reply_wait == 0) begin
                pkt_in_valid[p] = 1'b1;
                pkt_in_data[p]  = {4'd7, 4'd1, 25'($urandom)};
                reply_wait = -1;
            end else if (reply_wait > 0) begin
                reply_wait--;
            end
            if (row_valid[p] && row_ready[p]) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 30'h3fffffff;
                total++;
                if ({row_index[p], row_data[p]} !== e) begin
                    bad++;
                    $display("FAIL full_row%0d: idx=%0d data=%h want idx=%0d data=%h",
                             rows_popped, row_index[p], row_data[p], e[29:25], e[24:0]);
                end
                rows_popped++;
                if (rows_popped == 5) pop_cyc = cyc;
            end
            if (pkt_out_valid[p] && pkt_out_ready[p]) begin
                total++;
                if (pkt_out_data[p] !== {4'd10, 4'd7, 20'd0, 5'(2 + 5 * (reqs + 1))} ||
                    rows_sent != reqs + 1) begin
                    bad++;
                    $display("FAIL full_req%0d: data=%h rows_received=%0d want %h after %0d rows",
                             reqs, pkt_out_data[p], rows_sent,
                             {4'd10, 4'd7, 20'd0, 5'(2 + 5 * (reqs + 1))}, reqs + 1);
                end
                reqs++;
                reply_wait = $urandom_range(0, 4);
            end
            accepted = pkt_in_valid[p] && pkt_in_ready[p];
            if (accepted) begin
                exp_q.push_back({5'(2 + 5 * rows_sent), pkt_in_data[p][24:0]});
                rows_sent++;
            end
            tick();
            cyc++;
            if (accepted) pkt_in_valid[p] = 1'b0;
        end
        total++;
        if (rows_popped != 5 || reqs != 4) begin
            bad++;
            $display("FAIL full_counts: rows=%0d reqs=%0d want 5 4", rows_popped, reqs);
        end
        total++;
        if (done_pulses != 1 || done_cyc != pop_cyc + 1) begin
            bad++;
            $display("FAIL full_ts_done: pulses=%0d at cycle %0d want 1 at cycle %0d",
                     done_pulses, done_cyc, pop_cyc + 1);
        end
        total++;
        if (dbg_state[p] !== ST_DONE) begin
            bad++;
            $display("FAIL full_state: state=%0d want %0d", dbg_state[p], ST_DONE);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [24:0] d0, d1;
        int w = 0;
        apply_reset();
        do_start(0);
        pkt_out_ready[0] = 1'b1;
        d0 = 25'($urandom);
        d1 = 25'($urandom);
        send_pkt(0, 4'd5, 4'd1, d0);
        while (!pkt_out_valid[0] && w < 5) begin
            tick();
            w++;
        end
        total++;
        if (pkt_out_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_first_req: no request within %0d cycles", w);
        end
        tick();
        send_pkt(0, 4'd5, 4'd1, d1);
        total++;
        if (pkt_in_ready[0] !== 1'b0 || row_valid[0] !== 1'b1 || row_index[0] !== 5'd0) begin
            bad++;
            $display("FAIL bp_full: in_rdy=%b row_v=%b idx=%0d want 0 1 0",
                     pkt_in_ready[0], row_valid[0], row_index[0]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (pkt_out_valid[0] !== 1'b0 || pkt_in_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_blocked%0d: out_v=%b in_rdy=%b want 0 0",
                         i, pkt_out_valid[0], pkt_in_ready[0]);
            end
        end
        total++;
        if (row_data[0] !== d0) begin
            bad++;
            $display("FAIL bp_pop_data: data=%h want %h", row_data[0], d0);
        end
        row_ready[0] = 1'b1;
        tick();
        row_ready[0] = 1'b0;
        total++;
        if (row_index[0] !== 5'd5 || row_data[0] !== d1 || pkt_in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_after_pop: idx=%0d data=%h in_rdy=%b want 5 %h 1",
                     row_index[0], row_data[0], pkt_in_ready[0], d1);
        end
        pkt_out_ready[0] = 1'b0;
        tick();
        total++;
        if (pkt_out_valid[0] !== 1'b1 || pkt_out_data[0] !== {4'd10, 4'd5, 25'd10}) begin
            bad++;
            $display("FAIL bp_req_after_pop: out_v=%b data=%h want 1 %h",
                     pkt_out_valid[0], pkt_out_data[0], {4'd10, 4'd5, 25'd10});
        end
    endtask

    task automatic test_stray();
        logic [24:0] d0, d1;
        apply_reset();
        do_start(0);
        send_pkt(0, 4'd6, 4'd1, 25'($urandom));
        total++;
        if (err[0] !== 1'b1 || row_valid[0] !== 1'b0 || pkt_in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL stray_dest: err=%b row_v=%b in_rdy=%b want 1 0 1",
                     err[0], row_valid[0], pkt_in_ready[0]);
        end
        tick();
        total++;
        if (err[0] !== 1'b0) begin
            bad++;
            $display("FAIL stray_err_pulse: err=%b want 0", err[0]);
        end
        send_pkt(0, 4'd5, 4'd0, 25'($urandom));
        total++;
        if (err[0] !== 1'b1 || row_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL stray_opcode: err=%b row_v=%b want 1 0", err[0], row_valid[0]);
        end
        d0 = 25'($urandom);
        d1 = 25'($urandom);
        send_pkt(0, 4'd5, 4'd1, d0);
        total++;
        if (err[0] !== 1'b0 || row_valid[0] !== 1'b1 || row_index[0] !== 5'd0) begin
            bad++;
            $display("FAIL stray_good_row: err=%b row_v=%b idx=%0d want 0 1 0",
                     err[0], row_valid[0], row_index[0]);
        end
        tick();
        send_pkt(0, 4'd5, 4'd1, 25'($urandom));
        total++;
        if (err[0] !== 1'b1 || row_data[0] !== d0 || row_index[0] !== 5'd0 ||
            pkt_in_ready[0] !== 1'b1 || pkt_out_valid[0] !== 1'b1 ||
            pkt_out_data[0] !== {4'd10, 4'd5, 25'd5}) begin
            bad++;
            $display("FAIL stray_unsolicited: err=%b data=%h idx=%0d in_rdy=%b out_v=%b out_d=%h want 1 %h 0 1 1 %h",
                     err[0], row_data[0], row_index[0], pkt_in_ready[0], pkt_out_valid[0],
                     pkt_out_data[0], d0, {4'd10, 4'd5, 25'd5});
        end
        pkt_out_ready[0] = 1'b1;
        tick();
        pkt_out_ready[0] = 1'b0;
        send_pkt(0, 4'd5, 4'd1, d1);
        row_ready[0] = 1'b1;
        tick();
        row_ready[0] = 1'b0;
        total++;
        if (row_valid[0] !== 1'b1 || row_index[0] !== 5'd5 || row_data[0] !== d1) begin
            bad++;
            $display("FAIL stray_next_row: row_v=%b idx=%0d data=%h want 1 5 %h",
                     row_valid[0], row_index[0], row_data[0], d1);
        end
    endtask

    task automatic test_stall_restart();
        logic pend;
        apply_reset();
        do_start(0);
        send_pkt(0, 4'd5, 4'd1, 25'($urandom));
        tick();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (pkt_out_valid[0] !== 1'b1 || pkt_out_data[0] !== {4'd10, 4'd5, 25'd5}) begin
                bad++;
                $display("FAIL stall_hold%0d: out_v=%b data=%h want 1 %h",
                         i, pkt_out_valid[0], pkt_out_data[0], {4'd10, 4'd5, 25'd5});
            end
            ts_start[0] = (i == 5);
            tick();
        end
        ts_start[0] = 1'b0;
        pkt_out_ready[0] = 1'b1;
        tick();
        pkt_out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (pkt_out_valid[0] !== 1'b0) begin
                bad++;
                $display("FAIL stall_no_dup%0d: out_v=%b want 0", i, pkt_out_valid[0]);
            end
            tick();
        end
        row_ready[0] = 1'b1;
        pkt_out_ready[0] = 1'b1;
        pend = 1'b1;
        for (int c = 0; c < 60 && dbg_state[0] != ST_DONE; c++) begin
            pkt_in_valid[0] = 1'b0;
            if (pend) begin
                pkt_in_valid[0] = 1'b1;
                pkt_in_data[0]  = {4'd5, 4'd1, 25'($urandom)};
                pend = 1'b0;
            end
            if (pkt_out_valid[0]) pend = 1'b1;
            tick();
        end
        clear_inputs();
        total++;
        if (dbg_state[0] !== ST_DONE) begin
            bad++;
            $display("FAIL stall_reach_done: state=%0d want %0d", dbg_state[0], ST_DONE);
        end
        do_start(0);
        send_pkt(0, 4'd5, 4'd1, 25'h0155AA5);
        total++;
        if (row_valid[0] !== 1'b1 || row_index[0] !== 5'd0 || row_data[0] !== 25'h0155AA5) begin
            bad++;
            $display("FAIL restart_row: row_v=%b idx=%0d data=%h want 1 0 0155aa5",
                     row_valid[0], row_index[0], row_data[0]);
        end
        tick();
        total++;
        if (pkt_out_valid[0] !== 1'b1 || pkt_out_data[0] !== {4'd10, 4'd5, 25'd5}) begin
            bad++;
            $display("FAIL restart_req: out_v=%b data=%h want 1 %h",
                     pkt_out_valid[0], pkt_out_data[0], {4'd10, 4'd5, 25'd5});
        end
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_full_timestep();
        test_backpressure();
        test_stray();
        test_stall_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
